rx_spi_unpack: RTL and testbench

Receive-side counterpart of the CC1200 SPI sample transmitter. It runs one SPI burst read of the radio RX FIFO and unpacks the byte stream into 12-bit samples. Samples are packed three bytes per two samples: byte0=A[7:0], byte1={B[3:0],A[11:8]}, byte2=B[11:4]. Recovered samples are written to the receive sample buffer at incrementing addresses.

---
 rtl/rx_spi_pkg.sv | 6 +
 rtl/rx_spi_unpack_spi_byte_shift.sv | 53 +++++
 rtl/rx_spi_unpack.sv | 112 +++++++++++
 tb/tb_rx_spi_unpack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_spi_pkg.sv
// rx_spi_pkg: shared state, byte-phase encodings and CC1200 command constant for rx_spi_unpack
package rx_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, TAIL, DONE} state_t;
  typedef enum logic [1:0] {PH_LO, PH_MID, PH_HI} phase_t;
  localparam logic [7:0] CC1200_RX_BURST = 8'hFF;
endpackage

// File: rtl/rx_spi_unpack_spi_byte_shift.sv
// spi_byte_shift: mode-0 SCLK generator and 8-bit MSB-first shifter with a byte-complete pulse
module spi_byte_shift #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx;
  logic [6:0]    rx_sh;
  logic          tick, rise;
  assign tick      = en && cnt == CW'(CLK_DIV - 1);
  assign rise      = tick && !sclk;
  assign byte_done = rise && bit_cnt == 3'd7;
  assign rx_byte   = {rx_sh, miso};
  assign mosi      = tx[7];
  // Half-period divider; MISO captured on rising ticks, MOSI advanced on falling ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx_sh   <= '0;
      sclk    <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= tx_byte;
      sclk    <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) sclk <= !sclk;
      if (rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (tick && sclk) tx <= {tx[6:0], 1'b0};
    end
  end
endmodule

// File: rtl/rx_spi_unpack.sv
// rx_spi_unpack: CC1200 RX FIFO burst reader unpacking 3 bytes into two 12-bit samples (option RXSPI_STATUS_EN adds Status)
module rx_spi_unpack
  import rx_spi_pkg::*;
#(
  parameter int         CLK_DIV     = 16,
  parameter int         NUM_SAMPLES = 38400,
  parameter logic [7:0] CMD_BYTE    = CC1200_RX_BURST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RecStart,
  output logic        Busy,
  output logic        Done,
  output logic        WrEn,
  output logic [15:0] WrAdd,
  output logic [11:0] WrData,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS_n
`ifdef RXSPI_STATUS_EN
  , output logic [7:0] Status
`endif
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [16:0] LAST_BYTE = 17'(NUM_SAMPLES * 3 / 2 - 1);
  state_t        state;
  phase_t        phase;
  logic [CW-1:0] wait_cnt;
  logic [16:0]   byte_cnt;
  logic [15:0]   smp_cnt;
  logic [7:0]    low, rx_byte;
  logic [3:0]    nib;
  logic          load, en, byte_done;
  assign load = state == IDLE && RecStart;
  // Keep SCLK running into TAIL only long enough to finish the last high phase
  assign en   = state == CMD || state == DATA || (state == TAIL && SCLK);
  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(clk), .rst(rst), .en(en), .load(load), .tx_byte(CMD_BYTE), .miso(MISO),
    .sclk(SCLK), .mosi(MOSI), .byte_done(byte_done), .rx_byte(rx_byte)
  );
  // Burst sequencer with byte-phase unpacking and sample addressing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= PH_LO;
      wait_cnt <= '0;
      byte_cnt <= '0;
      smp_cnt  <= '0;
      low      <= '0;
      nib      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      WrEn     <= 1'b0;
      WrAdd    <= '0;
      WrData   <= '0;
      CS_n     <= 1'b1;
`ifdef RXSPI_STATUS_EN
      Status   <= '0;
`endif
    end else begin
      Done <= 1'b0;
      WrEn <= 1'b0;
      case (state)
        IDLE: if (RecStart) begin
          state    <= SETUP;
          Busy     <= 1'b1;
          CS_n     <= 1'b0;
          wait_cnt <= '0;
          smp_cnt  <= '0;
          WrAdd    <= '0;
        end
        SETUP: if (wait_cnt == CW'(CLK_DIV - 1)) state <= CMD;
               else wait_cnt <= wait_cnt + 1'b1;
        CMD: if (byte_done) begin
          state    <= DATA;
          byte_cnt <= '0;
          phase    <= PH_LO;
`ifdef RXSPI_STATUS_EN
          Status   <= rx_byte;
`endif
        end
        DATA: if (byte_done) begin
          byte_cnt <= byte_cnt + 17'd1;
          phase    <= phase == PH_LO ? PH_MID : phase == PH_MID ? PH_HI : PH_LO;
          if (phase == PH_LO) low <= rx_byte;
          else begin
            WrEn    <= 1'b1;
            WrAdd   <= smp_cnt;
            smp_cnt <= smp_cnt + 16'd1;
            WrData  <= phase == PH_MID ? {rx_byte[3:0], low} : {rx_byte, nib};
          end
          if (phase == PH_MID) nib <= rx_byte[7:4];
          if (byte_cnt == LAST_BYTE) begin
            state    <= TAIL;
            wait_cnt <= '0;
          end
        end
        TAIL: if (!SCLK) begin
          if (wait_cnt == CW'(CLK_DIV - 1)) begin
            state <= DONE;
            CS_n  <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_spi_unpack.sv
// tb_rx_spi_unpack: directed checks of rx_spi_unpack with SPI slave models (honours RXSPI_STATUS_EN)
module tb_rx_spi_unpack;
  logic clk = 0, rst = 1;
  logic rs2 = 0, rs4 = 0, miso2 = 0, miso4 = 0;
  logic busy2, done2, we2, sclk2, mosi2, cs2;
  logic busy4, done4, we4, sclk4, mosi4, cs4;
  logic [15:0] wadd2, wadd4;
  logic [11:0] wdat2, wdat4;
  logic [7:0] st2, st4;
  logic [7:0] s2 [0:7];
  logic [7:0] s4 [0:7];
  logic [7:0] b2, b4;
  int i2, i4;
  int checks = 0, errors = 0;
  int cyc = 0, n2 = 0, n4 = 0, nd2 = 0, nd4 = 0, rise2 = 0, rise4 = 0;
  int csbad2 = 0, perbad2 = 0, last2 = -1000;
  logic p_sclk2 = 0, p_sclk4 = 0;
  logic [63:0] mlog2 = '0;
  logic [15:0] wa2 [0:63];
  logic [11:0] wd2 [0:63];
  logic [15:0] wa4 [0:63];
  logic [11:0] wd4 [0:63];

  always #5 clk = ~clk;

  rx_spi_unpack #(.CLK_DIV(2), .NUM_SAMPLES(2)) u2 (
    .clk(clk), .rst(rst), .RecStart(rs2), .Busy(busy2), .Done(done2), .WrEn(we2),
    .WrAdd(wadd2), .WrData(wdat2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2),
`ifdef RXSPI_STATUS_EN
    .Status(st2),
`endif
    .CS_n(cs2)
  );

  rx_spi_unpack #(.CLK_DIV(2), .NUM_SAMPLES(4)) u4 (
    .clk(clk), .rst(rst), .RecStart(rs4), .Busy(busy4), .Done(done4), .WrEn(we4),
    .WrAdd(wadd4), .WrData(wdat4), .SCLK(sclk4), .MOSI(mosi4), .MISO(miso4),
`ifdef RXSPI_STATUS_EN
    .Status(st4),
`endif
    .CS_n(cs4)
  );

`ifndef RXSPI_STATUS_EN
  assign st2 = '0;
  assign st4 = '0;
`endif

  always @(negedge cs2) begin i2 = 0; b2 = s2[0]; miso2 = b2[7]; end
  always @(negedge sclk2) if (!cs2) begin
    i2 = i2 + 1;
    if (i2 < 64) begin b2 = s2[i2 / 8]; miso2 = b2[7 - (i2 % 8)]; end
  end
  always @(negedge cs4) begin i4 = 0; b4 = s4[0]; miso4 = b4[7]; end
  always @(negedge sclk4) if (!cs4) begin
    i4 = i4 + 1;
    if (i4 < 64) begin b4 = s4[i4 / 8]; miso4 = b4[7 - (i4 % 8)]; end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    p_sclk2 <= sclk2;
    p_sclk4 <= sclk4;
    if (we2) begin wa2[n2 % 64] <= wadd2; wd2[n2 % 64] <= wdat2; n2 <= n2 + 1; end
    if (we4) begin wa4[n4 % 64] <= wadd4; wd4[n4 % 64] <= wdat4; n4 <= n4 + 1; end
    if (done2) nd2 <= nd2 + 1;
    if (done4) nd4 <= nd4 + 1;
    if (sclk4 && !p_sclk4) rise4 <= rise4 + 1;
    if (sclk2 && !p_sclk2) begin
      rise2 <= rise2 + 1;
      mlog2 <= {mlog2[62:0], mosi2};
      if (cs2) csbad2 <= csbad2 + 1;
      if (cyc - last2 != 4 && cyc - last2 < 40) perbad2 <= perbad2 + 1;
      last2 <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit four);
    @(negedge clk);
    if (four) rs4 = 1; else rs2 = 1;
    @(negedge clk);
    rs2 = 0;
    rs4 = 0;
    #1;
  endtask

  task automatic wait_done(input bit four, input string tag);
    int k = 0;
    while ((four ? done4 : done2) !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    chk({tag, " done_seen"}, 64'(k < 2000), 1);
    chk({tag, " cs_n_at_done"}, 64'(four ? cs4 : cs2), 1);
    chk({tag, " busy_at_done"}, 64'(four ? busy4 : busy2), 0);
  endtask

  task automatic chk4(input string tag, input int n0);
    logic [11:0] ev [0:3];
    ev[0] = 12'hFFF; ev[1] = 12'h000; ev[2] = 12'h000; ev[3] = 12'hFFF;
    chk({tag, " strobes"}, 64'(n4 - n0), 4);
    for (int j = 0; j < 4; j++) begin
      chk({tag, " addr"}, 64'(wa4[(n0 + j) % 64]), 64'(j));
      chk({tag, " data"}, 64'(wd4[(n0 + j) % 64]), 64'(ev[j]));
    end
  endtask

  initial begin
    int n0, d0, r0, k;
    for (int j = 0; j < 8; j++) begin s2[j] = 8'h00; s4[j] = 8'h00; end
    s2[0] = 8'h0F; s2[1] = 8'h23; s2[2] = 8'hC1; s2[3] = 8'hAB;
    s4[0] = 8'h5A; s4[1] = 8'hFF; s4[2] = 8'h0F; s4[5] = 8'hF0; s4[6] = 8'hFF;
    tick(3);
    chk("reset_outputs", {30'd0, busy2, done2, we2, wadd2, wdat2, sclk2, mosi2, cs2}, 64'd1);
    chk("reset_status", 64'(st2), 0);
    rst = 0;
    tick(3);

    n0 = n2; d0 = nd2; r0 = rise2;
    pulse(0);
    chk("t1 busy_after_start", 64'(busy2), 1);
    chk("t1 cs_low_setup", 64'(cs2), 0);
    chk("t1 mosi_setup", 64'(mosi2), 1);
    wait_done(0, "t1");
    tick(5);
    chk("t1 strobes", 64'(n2 - n0), 2);
    chk("t1 addr0", 64'(wa2[n0 % 64]), 0);
    chk("t1 data0", 64'(wd2[n0 % 64]), 64'h123);
    chk("t1 addr1", 64'(wa2[(n0 + 1) % 64]), 1);
    chk("t1 data1", 64'(wd2[(n0 + 1) % 64]), 64'hABC);
    chk("t1 done_pulses", 64'(nd2 - d0), 1);
    chk("t2 sclk_rises", 64'(rise2 - r0), 32);
    chk("t2 mosi_bits", mlog2[31:0], 64'hFF00_0000);
    chk("t2 cs_high_at_rise", 64'(csbad2), 0);
    chk("t2 period_errors", 64'(perbad2), 0);
`ifdef RXSPI_STATUS_EN
    chk("t6 status_cmd_byte", 64'(st2), 64'h0F);
`endif

    tick(50);
    n0 = n2; d0 = nd2;
    pulse(0);
    tick(20);
    pulse(0);
    wait_done(0, "t4");
    rs2 = 1;
    @(negedge clk);
    rs2 = 0;
    tick(300);
    chk("t4 strobes", 64'(n2 - n0), 2);
    chk("t4 addr0", 64'(wa2[n0 % 64]), 0);
    chk("t4 addr1", 64'(wa2[(n0 + 1) % 64]), 1);
    chk("t4 single_done", 64'(nd2 - d0), 1);
    chk("t4 idle_after_done_start", 64'(busy2), 0);
    n0 = n2; d0 = nd2;
    pulse(0);
    wait_done(0, "t4r");
    tick(5);
    chk("t4r strobes", 64'(n2 - n0), 2);
    chk("t4r addr0", 64'(wa2[n0 % 64]), 0);
    chk("t4r data0", 64'(wd2[n0 % 64]), 64'h123);
    chk("t4r data1", 64'(wd2[(n0 + 1) % 64]), 64'hABC);

    n0 = n4; d0 = nd4;
    pulse(1);
    wait_done(1, "t3");
    tick(5);
    chk4("t3", n0);
    chk("t3 done_pulses", 64'(nd4 - d0), 1);

    tick(20);
    n0 = n4; d0 = nd4; r0 = rise4;
    pulse(1);
    k = 0;
    while (rise4 - r0 < 40 && k < 3000) begin tick(1); k++; end
    chk("t5 reached_byte4", 64'(k < 3000), 1);
    chk("t5 busy_before_rst", 64'(busy4), 1);
    rst = 1;
    tick(1);
    chk("t5 after_rst", {59'd0, cs4, sclk4, we4, busy4, done4}, 64'b10000);
    chk("t5 partial_writes", 64'(n4 - n0), 2);
    tick(200);
    chk("t5 no_done", 64'(nd4 - d0), 0);
    chk("t6 status_cleared", 64'(st2), 0);
    rst = 0;
    tick(5);
    n0 = n4; d0 = nd4;
    pulse(1);
    wait_done(1, "t5r");
    tick(5);
    chk4("t5r", n0);
    chk("t5r done_pulses", 64'(nd4 - d0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
